state_vector_streamer: RTL and testbench

- Parametrised, registered successor to the combinational state-to-input-layer encoder.
- Accepts a discrete environment state index over a valid/ready handshake and expands it into an N_STATES-element fixed-point input vector.
- Two encodings: one-hot or thermometer.
- Output paths: a held parallel vector, plus an element-serial valid/ready stream for time-multiplexed forward-pass MAC units.

---
 rtl/state_vector_streamer_if.sv | 31 +++
 rtl/state_vector_streamer.sv | 114 +++++++++++
 tb/tb_state_vector_streamer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/state_vector_streamer_if.sv
// Handshake bundle for the state vector streamer: state request in, parallel vector
// and element-serial stream out.
interface state_vector_streamer_if #(
   parameter int N_STATES = 9,
   parameter int ST_W     = 4,
   parameter int DATA_W   = 16
);
   logic                         st_valid;
   logic                         st_ready;
   logic [ST_W-1:0]              st;
   logic                         mode;
   logic [N_STATES*DATA_W-1:0]   vec;
   logic                         vec_valid;
   logic                         out_valid;
   logic                         out_ready;
   logic [DATA_W-1:0]            out_data;
   logic [ST_W-1:0]              out_idx;
   logic                         out_last;
   logic                         err_range;

   // The streamer itself sits on the slave side.
   modport slave (
      input  st_valid, st, mode, out_ready,
      output st_ready, vec, vec_valid, out_valid, out_data, out_idx, out_last, err_range
   );

   modport master (
      output st_valid, st, mode, out_ready,
      input  st_ready, vec, vec_valid, out_valid, out_data, out_idx, out_last, err_range
   );
endinterface

// File: rtl/state_vector_streamer.sv
// Registered state-index encoder: expands an accepted state into a one-hot or
// thermometer fixed-point vector, held in parallel and streamed element by element.
module state_vector_streamer #(
   parameter int N_STATES  = 9,
   parameter int ST_W      = 4,
   parameter int DATA_W    = 16,
   parameter int FRAC_W    = 10,
   parameter int ONE_BASED = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   state_vector_streamer_if.slave  bus_io
);

   localparam int                 LAST     = N_STATES - 1;
   localparam int                 POS_W    = ST_W + 2;
   localparam logic [DATA_W-1:0]  ONE      = DATA_W'(1) << FRAC_W;
   localparam logic [ST_W-1:0]    LAST_IDX = ST_W'(LAST);

   typedef enum logic {IDLE, STREAM} state_e;

   state_e                        state_q, state_d;
   logic [N_STATES*DATA_W-1:0]    vec_q, vec_d, encVec;
   logic                          vecValid_q, vecValid_d;
   logic [ST_W-1:0]               idx_q, idx_d, nextIdx;
   logic [DATA_W-1:0]             outData_q, outData_d;
   logic                          outLast_q, outLast_d;
   logic                          errRange_q, errRange_d;
   logic signed [POS_W-1:0]       pos;
   logic                          inRange;

   // Two extra bits keep st - ONE_BASED from wrapping, so st=0 reads as negative.
   assign pos     = $signed({2'b00, bus_io.st}) - $signed(POS_W'(ONE_BASED));
   assign inRange = !pos[POS_W-1] && (pos <= $signed(POS_W'(LAST)));
   assign nextIdx = idx_q + ST_W'(1);

   always_comb begin
      encVec = '0;
      for (int i = 0; i < N_STATES; i++) begin
         if (inRange && (bus_io.mode ? (ST_W'(i) <= pos[ST_W-1:0])
                                     : (ST_W'(i) == pos[ST_W-1:0]))) begin
            encVec[i*DATA_W +: DATA_W] = ONE;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      vecValid_d = vecValid_q;
      idx_d      = idx_q;
      outData_d  = outData_q;
      outLast_d  = outLast_q;
      errRange_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus_io.st_valid) begin
               state_d    = STREAM;
               vec_d      = encVec;
               vecValid_d = 1'b1;
               idx_d      = '0;
               outData_d  = encVec[DATA_W-1:0];
               outLast_d  = 1'b0;
               errRange_d = !inRange;
            end
         end
         STREAM: begin
            if (bus_io.out_ready) begin
               if (outLast_q) begin
                  state_d   = IDLE;
                  idx_d     = '0;
                  outData_d = '0;
                  outLast_d = 1'b0;
               end else begin
                  idx_d     = nextIdx;
                  outData_d = vec_q[int'(nextIdx)*DATA_W +: DATA_W];
                  outLast_d = (nextIdx == LAST_IDX);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         vec_q      <= '0;
         vecValid_q <= 1'b0;
         idx_q      <= '0;
         outData_q  <= '0;
         outLast_q  <= 1'b0;
         errRange_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         vecValid_q <= vecValid_d;
         idx_q      <= idx_d;
         outData_q  <= outData_d;
         outLast_q  <= outLast_d;
         errRange_q <= errRange_d;
      end
   end

   assign bus_io.st_ready  = (state_q == IDLE);
   assign bus_io.out_valid = (state_q == STREAM);
   assign bus_io.vec       = vec_q;
   assign bus_io.vec_valid = vecValid_q;
   assign bus_io.out_data  = outData_q;
   assign bus_io.out_idx   = idx_q;
   assign bus_io.out_last  = outLast_q;
   assign bus_io.err_range = errRange_q;

endmodule

// File: tb/tb_state_vector_streamer.sv
// Directed bench for state_vector_streamer: table of encodings plus hand-written
// backpressure, mid-stream reset and reparametrised sequences.
module tb_state_vector_streamer;

   localparam logic [15:0] ONE  = 16'h0400;
   localparam logic [11:0] ONE2 = 12'h100;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic       mode;
      logic [3:0] st;
      logic [8:0] mask;
      logic       err;
   } vec_t;

   vec_t vectors[8];

   state_vector_streamer_if #(.N_STATES(9),  .ST_W(4), .DATA_W(16)) bus();
   state_vector_streamer_if #(.N_STATES(16), .ST_W(5), .DATA_W(12)) bus2();

   state_vector_streamer dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus.slave)
   );

   state_vector_streamer #(
      .N_STATES(16), .ST_W(5), .DATA_W(12), .FRAC_W(8), .ONE_BASED(0)
   ) dut2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus2.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Waits (bounded) for st_ready, then holds st_valid for exactly one accept edge.
   task automatic applyStimulus(input logic m, input logic [3:0] s);
      int waitCycles = 0;
      while (bus.st_ready !== 1'b1 && waitCycles < 50) begin
         @(posedge clk);
         #1;
         waitCycles++;
      end
      checkOutput("st_ready before accept", 64'(bus.st_ready), 64'd1);
      bus.st       = s;
      bus.mode     = m;
      bus.st_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.st_valid = 1'b0;
   endtask

   // Consumes all nine elements, optionally with a 1,0,0,1 ready pattern.
   task automatic drainStream(input string tag, input logic [8:0] mask, input bit stall);
      int e   = 0;
      int cyc = 0;
      while (e < 9 && cyc < 100) begin
         bus.out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         checkOutput($sformatf("%s e%0d out_valid", tag, e), 64'(bus.out_valid), 64'd1);
         checkOutput($sformatf("%s e%0d out_idx", tag, e), 64'(bus.out_idx), 64'(e));
         checkOutput($sformatf("%s e%0d out_data", tag, e), 64'(bus.out_data),
                     mask[e] ? 64'(ONE) : 64'd0);
         checkOutput($sformatf("%s e%0d out_last", tag, e), 64'(bus.out_last), 64'(e == 8));
         checkOutput($sformatf("%s e%0d st_ready", tag, e), 64'(bus.st_ready), 64'd0);
         @(posedge clk);
         #1;
         if (bus.out_ready) e++;
         cyc++;
      end
      checkOutput($sformatf("%s element count", tag), 64'(e), 64'd9);
      bus.out_ready = 1'b1;
   endtask

   initial begin
      vectors[0] = '{1'b0, 4'd3,  9'b000000100, 1'b0};
      vectors[1] = '{1'b1, 4'd5,  9'b000011111, 1'b0};
      vectors[2] = '{1'b0, 4'd0,  9'b000000000, 1'b1};
      vectors[3] = '{1'b0, 4'd12, 9'b000000000, 1'b1};
      vectors[4] = '{1'b1, 4'd9,  9'b111111111, 1'b0};
      vectors[5] = '{1'b0, 4'd9,  9'b100000000, 1'b0};
      vectors[6] = '{1'b1, 4'd1,  9'b000000001, 1'b0};
      vectors[7] = '{1'b1, 4'd10, 9'b000000000, 1'b1};

      bus.st_valid  = 1'b0;
      bus.st        = '0;
      bus.mode      = 1'b0;
      bus.out_ready = 1'b1;
      bus2.st_valid  = 1'b0;
      bus2.st        = '0;
      bus2.mode      = 1'b0;
      bus2.out_ready = 1'b1;

      // Reset values while rst_n is held low.
      #2 rst_n = 1'b0;
      #2;
      checkOutput("reset vec_valid", 64'(bus.vec_valid), 64'd0);
      checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("reset vec zero", 64'(bus.vec == '0), 64'd1);
      checkOutput("reset out_data", 64'(bus.out_data), 64'd0);
      checkOutput("reset out_idx", 64'(bus.out_idx), 64'd0);
      checkOutput("reset out_last", 64'(bus.out_last), 64'd0);
      checkOutput("reset err_range", 64'(bus.err_range), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("st_ready after reset", 64'(bus.st_ready), 64'd1);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vectors[i].mode, vectors[i].st);
         checkOutput($sformatf("v%0d err_range", i), 64'(bus.err_range), 64'(vectors[i].err));
         checkOutput($sformatf("v%0d vec_valid", i), 64'(bus.vec_valid), 64'd1);
         for (int e = 0; e < 9; e++) begin
            checkOutput($sformatf("v%0d vec[%0d]", i, e), 64'(bus.vec[e*16 +: 16]),
                        vectors[i].mask[e] ? 64'(ONE) : 64'd0);
         end
         drainStream($sformatf("v%0d", i), vectors[i].mask, 1'b0);
         checkOutput($sformatf("v%0d out_valid after last", i), 64'(bus.out_valid), 64'd0);
         checkOutput($sformatf("v%0d st_ready after last", i), 64'(bus.st_ready), 64'd1);
         checkOutput($sformatf("v%0d err_range after", i), 64'(bus.err_range), 64'd0);
      end

      // Backpressure with a new request held pending throughout the stream.
      applyStimulus(1'b0, 4'd9);
      bus.st       = 4'd1;
      bus.mode     = 1'b0;
      bus.st_valid = 1'b1;
      checkOutput("stall err_range", 64'(bus.err_range), 64'd0);
      drainStream("stall", 9'b100000000, 1'b1);
      checkOutput("stall out_valid after last", 64'(bus.out_valid), 64'd0);
      checkOutput("stall st_ready after last", 64'(bus.st_ready), 64'd1);
      checkOutput("stall vec held", 64'(bus.vec[143:128]), 64'(ONE));
      @(posedge clk);
      #1;
      bus.st_valid = 1'b0;
      checkOutput("pending accepted out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("pending vec[0]", 64'(bus.vec[15:0]), 64'(ONE));
      checkOutput("pending vec[8]", 64'(bus.vec[143:128]), 64'd0);
      drainStream("pending", 9'b000000001, 1'b0);

      // Asynchronous reset part-way through a stream.
      applyStimulus(1'b1, 4'd7);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      checkOutput("midreset idx before", 64'(bus.out_idx), 64'd4);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("midreset vec_valid", 64'(bus.vec_valid), 64'd0);
      checkOutput("midreset vec zero", 64'(bus.vec == '0), 64'd1);
      checkOutput("midreset out_idx", 64'(bus.out_idx), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 4'd1);
      checkOutput("post-reset err_range", 64'(bus.err_range), 64'd0);
      checkOutput("post-reset vec_valid", 64'(bus.vec_valid), 64'd1);
      drainStream("postreset", 9'b000000001, 1'b0);

      // Reparametrised instance: zero-based, 16 elements of 12 bits.
      checkOutput("p2 st_ready", 64'(bus2.st_ready), 64'd1);
      bus2.st       = 5'd15;
      bus2.mode     = 1'b0;
      bus2.st_valid = 1'b1;
      @(posedge clk);
      #1;
      bus2.st_valid = 1'b0;
      checkOutput("p2 err_range", 64'(bus2.err_range), 64'd0);
      checkOutput("p2 vec[15]", 64'(bus2.vec[191:180]), 64'(ONE2));
      checkOutput("p2 vec low zero", 64'(bus2.vec[179:0] == '0), 64'd1);
      for (int e = 0; e < 16; e++) begin
         checkOutput($sformatf("p2 e%0d out_valid", e), 64'(bus2.out_valid), 64'd1);
         checkOutput($sformatf("p2 e%0d out_idx", e), 64'(bus2.out_idx), 64'(e));
         checkOutput($sformatf("p2 e%0d out_data", e), 64'(bus2.out_data),
                     (e == 15) ? 64'(ONE2) : 64'd0);
         checkOutput($sformatf("p2 e%0d out_last", e), 64'(bus2.out_last), 64'(e == 15));
         @(posedge clk);
         #1;
      end
      checkOutput("p2 out_valid after last", 64'(bus2.out_valid), 64'd0);
      checkOutput("p2 st_ready after last", 64'(bus2.st_ready), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
